// File: rtl/npc_sched_pkg.sv
// rtl/npc_sched_pkg.sv - shared types and constants for the next-PC scheduler
package npc_sched_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_LEAVE   = 2'd3
    } state_t;

    typedef enum logic {
        EPC_SRC_PIPE  = 1'b0,
        EPC_SRC_FETCH = 1'b1
    } epc_src_t;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE_BIT  = 0;
    localparam int SR_EXL_BIT = 1;
    localparam int SR_IM_LSB  = 10;
    localparam int SR_IM_MSB  = 15;
    localparam int IM_W       = SR_IM_MSB - SR_IM_LSB + 1;

    localparam logic CFG_ADDR_SR  = 1'b0;
    localparam logic CFG_ADDR_EPC = 1'b1;

    function automatic logic [31:0] sr_pack(input logic [IM_W-1:0] im,
                                            input logic exl,
                                            input logic ie);
        logic [31:0] v;
        v                       = '0;
        v[SR_IM_MSB:SR_IM_LSB]  = im;
        v[SR_EXL_BIT]           = exl;
        v[SR_IE_BIT]            = ie;
        return v;
    endfunction

endpackage

// File: rtl/npc_sched_if.sv
// rtl/npc_sched_if.sv - pipeline-control and PC-register side signals of the scheduler
interface npc_sched_if;
    logic        stall;
    logic [31:0] pc_cur;
    logic [4:0]  fetch_exc;
    logic        br_valid;
    logic [31:0] br_target;
    logic [4:0]  pipe_exc;
    logic [31:0] pipe_epc;
    logic        eret;
    logic [5:0]  irq;
    logic        cfg_we;
    logic        cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        pc_update;
    logic [31:0] pc_next;
    logic        flush;
    logic [4:0]  exc_code;
    logic        exl;

    modport master (
        output stall, pc_cur, fetch_exc, br_valid, br_target, pipe_exc,
               pipe_epc, eret, irq, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_rdata, pc_update, pc_next, flush, exc_code, exl
    );

    modport slave (
        input  stall, pc_cur, fetch_exc, br_valid, br_target, pipe_exc,
               pipe_epc, eret, irq, cfg_we, cfg_addr, cfg_wdata,
        output cfg_rdata, pc_update, pc_next, flush, exc_code, exl
    );
endinterface

// File: rtl/npc_sched_exc_prio_enc.sv
// rtl/npc_sched_exc_prio_enc.sv - picks the winning exception/interrupt request
module exc_prio_enc
    import npc_sched_pkg::*;
(
    input  logic [4:0] i_pipe_exc,
    input  logic [4:0] i_fetch_exc,
    input  logic       i_int_pend,
    output logic       o_req,
    output logic [4:0] o_code,
    output epc_src_t   o_epc_src
);

    // Oldest pipeline fault outranks the fetch fault, which outranks interrupts.
    always_comb begin
        o_req     = 1'b0;
        o_code    = EXC_INT;
        o_epc_src = EPC_SRC_PIPE;
        if (i_pipe_exc != 5'd0) begin
            o_req  = 1'b1;
            o_code = i_pipe_exc;
        end else if (i_fetch_exc != 5'd0) begin
            o_req     = 1'b1;
            o_code    = i_fetch_exc;
            o_epc_src = EPC_SRC_FETCH;
        end else if (i_int_pend) begin
            o_req  = 1'b1;
            o_code = EXC_INT;
        end
    end

endmodule

// File: rtl/npc_sched.sv
// rtl/npc_sched.sv - next-PC scheduler and exception sequencer; NPC_SCHED_IRQ_EN enables the interrupt path
module npc_sched
    import npc_sched_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic       clk,
    input  logic       reset,
    npc_sched_if.slave bus
);

    state_t          r_state;
    state_t          w_next_state;
    logic [31:0]     r_epc;
    logic [4:0]      r_exc_code;
    logic            r_exl;
    logic            r_ie;
    logic [IM_W-1:0] r_im;

    logic            w_int_pend;
    logic            w_req;
    logic [4:0]      w_code;
    epc_src_t        w_epc_src;
    logic [31:0]     w_req_epc;
    logic [31:0]     w_seq_pc;
    logic            w_pc_update;
    logic [31:0]     w_pc_next;
    logic            w_flush;
    logic            w_epc_cap;
    logic            w_code_cap;
    logic            w_exl_set;
    logic            w_exl_clr;
    logic            w_sr_we;
    logic            w_epc_we;

`ifdef NPC_SCHED_IRQ_EN
    assign w_int_pend = (|(bus.irq & r_im)) & r_ie & ~r_exl & (r_state == ST_RUN);
`else
    assign w_int_pend = 1'b0;
`endif

    exc_prio_enc u_prio (
        .i_pipe_exc  (bus.pipe_exc),
        .i_fetch_exc (bus.fetch_exc),
        .i_int_pend  (w_int_pend),
        .o_req       (w_req),
        .o_code      (w_code),
        .o_epc_src   (w_epc_src)
    );

    assign w_req_epc = (w_epc_src == EPC_SRC_FETCH) ? bus.pc_cur : bus.pipe_epc;
    assign w_seq_pc  = bus.br_valid ? bus.br_target : bus.pc_cur + 32'd4;
    assign w_sr_we   = bus.cfg_we & (bus.cfg_addr == CFG_ADDR_SR);
    assign w_epc_we  = bus.cfg_we & (bus.cfg_addr == CFG_ADDR_EPC);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_update  = 1'b0;
        w_pc_next    = RESET_PC;
        w_flush      = 1'b0;
        w_epc_cap    = 1'b0;
        w_code_cap   = 1'b0;
        w_exl_set    = 1'b0;
        w_exl_clr    = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_pc_next = w_seq_pc;
                if (w_req) begin
                    w_next_state = ST_ENTER;
                    w_epc_cap    = 1'b1;
                    w_code_cap   = 1'b1;
                end else begin
                    w_pc_update = ~bus.stall;
                end
            end
            ST_ENTER: begin
                w_pc_update  = 1'b1;
                w_pc_next    = HANDLER_PC;
                w_flush      = 1'b1;
                w_exl_set    = 1'b1;
                w_next_state = ST_HANDLER;
            end
            ST_HANDLER: begin
                // Nested faults keep the original EPC so ERET still returns to user code.
                w_pc_next = w_seq_pc;
                if (w_req) begin
                    w_next_state = ST_ENTER;
                    w_code_cap   = 1'b1;
                end else if (bus.eret) begin
                    w_next_state = ST_LEAVE;
                end else begin
                    w_pc_update = ~bus.stall;
                end
            end
            ST_LEAVE: begin
                w_pc_update  = 1'b1;
                w_pc_next    = r_epc;
                w_flush      = 1'b1;
                w_exl_clr    = 1'b1;
                w_next_state = ST_RUN;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
        if (reset) begin
            w_pc_update = 1'b0;
            w_pc_next   = RESET_PC;
            w_flush     = 1'b0;
        end
    end

    // Hardware captures take priority over software writes in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_epc      <= '0;
            r_exc_code <= EXC_INT;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_im       <= '0;
        end else begin
            if (w_epc_cap) begin
                r_epc <= w_req_epc;
            end else if (w_epc_we) begin
                r_epc <= bus.cfg_wdata;
            end
            if (w_code_cap) begin
                r_exc_code <= w_code;
            end
            if (w_exl_set) begin
                r_exl <= 1'b1;
            end else if (w_exl_clr) begin
                r_exl <= 1'b0;
            end else if (w_sr_we) begin
                r_exl <= bus.cfg_wdata[SR_EXL_BIT];
            end
`ifdef NPC_SCHED_IRQ_EN
            if (w_sr_we) begin
                r_ie <= bus.cfg_wdata[SR_IE_BIT];
                r_im <= bus.cfg_wdata[SR_IM_MSB:SR_IM_LSB];
            end
`else
            r_ie <= 1'b0;
            r_im <= '0;
`endif
        end
    end

    assign bus.cfg_rdata = (bus.cfg_addr == CFG_ADDR_SR) ? sr_pack(r_im, r_exl, r_ie) : r_epc;
    assign bus.pc_update = w_pc_update;
    assign bus.pc_next   = w_pc_next;
    assign bus.flush     = w_flush;
    assign bus.exc_code  = r_exc_code;
    assign bus.exl       = r_exl;

endmodule

// File: doc/npc_sched.md
# npc_sched

Next-PC scheduler and exception sequencer for the MIPS pipeline. Each cycle it decides whether the fetch PC register loads and with what value: sequential `pc+4`, branch/jump target, exception-handler entry, or return to EPC. It owns EPC, EXL, IE and the interrupt mask, so it is the single place where the Timer interrupt, fetch-address faults and pipeline exceptions are arbitrated against normal control flow. It sits between the pipeline control logic and the PC register, driving that register's update enable and next-PC input.

## Interface
- `RESET_PC`, default `32'h0000_3000`, value of `pc_next` while idle or in reset.
- `HANDLER_PC`, default `32'h0000_4180`, exception and interrupt entry address.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  pipeline hazard stall; holds the PC in RUN.
- `pc_cur`  in  32  current PC-register value.
- `fetch_exc`  in  5  fetch-stage fault code from the PC register; 0 means none, 4 means AdEL.
- `br_valid`  in  1  branch/jump taken this cycle.
- `br_target`  in  32  branch/jump target.
- `pipe_exc`  in  5  code of the oldest faulting instruction; 0 means none.
- `pipe_epc`  in  32  PC of the oldest in-flight instruction.
- `eret`  in  1  ERET has reached commit.
- `irq`  in  6  hardware interrupt lines; bit 0 is the Timer.
- `cfg_we`  in  1  configuration register write strobe.
- `cfg_addr`  in  1  register select: 0 = SR, 1 = EPC.
- `cfg_wdata`  in  32  write data.
- `cfg_rdata`  out  32  combinational read of the selected register.
- `pc_update`  out  1  PC-register load enable.
- `pc_next`  out  32  PC-register load value.
- `flush`  out  1  kill all younger pipeline stages.
- `exc_code`  out  5  latched cause of the last entry.
- `exl`  out  1  exception level.

## Operation
- SR layout: IM = `[15:10]`, EXL = `[1]`, IE = `[0]`; all other bits read 0.
- Interrupt pending = `|(irq & IM) & IE & !EXL`.
- States:
  - RUN: normal execution, EXL=0.
  - ENTER: one cycle, handler entry.
  - HANDLER: EXL=1.
  - LEAVE: one cycle, return to EPC.
- Priority in RUN, highest first:
  1. `pipe_exc != 0`: EPC←`pipe_epc`.
  2. `fetch_exc != 0`: EPC←`pc_cur`.
  3. Interrupt pending: EPC←`pipe_epc`, code 0.
  4. Branch.
  5. Sequential.
- A request from items 1–3 latches EPC and `exc_code`, then moves to ENTER. `eret` in RUN is ignored.
- RUN, no request: `pc_update = !stall`; `pc_next = br_valid ? br_target : pc_cur+4`, with 32-bit wrap.
- ENTER: `pc_update=1`, `pc_next=HANDLER_PC`, `flush=1`, EXL←1; then HANDLER. Stall is ignored.
- HANDLER: behaves like RUN but interrupts are masked.
  - `eret`: go to LEAVE.
  - A new exception goes to ENTER without overwriting EPC; `exc_code` is updated.
  - `pipe_exc` beats `eret` when both are asserted.
- LEAVE: `pc_update=1`, `pc_next=EPC`, `flush=1`, EXL←0; then RUN. Stall is ignored.
- Config writes take effect at the edge. If an exception capture of EPC or EXL happens in the same cycle, the capture wins. Writes to bits other than IM/EXL/IE are dropped.

## Timing
- Reset values:
  - State RUN.
  - EPC=0, IM=0, IE=0, EXL=0, `exc_code`=0.
  - `pc_update=0`, `flush=0`, `pc_next=RESET_PC`.
- Reset mid-ENTER or mid-LEAVE returns to RUN next cycle with no residual `flush`.
- Exception or interrupt latency: request sampled at edge N; `pc_update`+`flush` asserted in cycle N+1; PC holds `HANDLER_PC` after edge N+1.
- ERET latency: identical, one cycle, with `pc_next=EPC`.
- Branch and sequential updates are combinational, with zero added latency.
- An `irq` pulse shorter than one cycle may be missed. The Timer holds its line, so this is acceptable.

## Configuration
- `NPC_SCHED_IRQ_EN` defined: interrupt path as described.
- Undefined:
  - `irq` is ignored.
  - IM and IE read 0 and their writes are dropped.
  - Only synchronous exceptions can reach ENTER.

## Structure
- Shared package `npc_sched_pkg`:
  - State enum.
  - ExcCode constants: `EXC_INT`=0, `EXC_ADEL`=4, `EXC_ADES`=5, `EXC_RI`=10, `EXC_OV`=12.
  - SR bit positions.
  - Config address constants.
- One sub-module, `exc_prio_enc`: a combinational priority encoder producing request-valid, code and EPC source.

## Test plan
- Reset, then release with `stall=0` and `pc_cur=0x3000` → `pc_update=1`, `pc_next=0x3004`; with `stall=1` → `pc_update=0`.
- `fetch_exc=4`, `pc_cur=0x3002` → next cycle `flush=1`, `pc_next=0x4180`; then `exc_code=4`, EPC=`0x3002`, `exl=1`.
- SR←`0x0401` and `irq[0]=1` with `pipe_epc=0x3010` → entry with code 0 and EPC=`0x3010`; in HANDLER with `irq` held, no second entry.
- In HANDLER with EPC=`0x3010`, `eret=1` → next cycle `pc_next=0x3010`, `flush=1`; then `exl=0`, back in RUN.
- Same cycle `pipe_exc=12`, `fetch_exc=4`, `br_valid=1` → `exc_code=12`, EPC=`pipe_epc`, and no branch update.
- `reset` asserted during ENTER → next cycle `pc_update=0`, `flush=0`, `exl=0`.
